violation_reset_ctrl: RTL and testbench
=======================================

// Module: violation_reset_ctrl
// PURPOSE
//  Consumes the per-monitor violation pulses from the hardware monitor top (X_stack, AC, atomicity,
//  dma_AC, dma_detect, dma_X_stack). Stretches them into a clean CPU reset of fixed length and
//  checks that the core restarts at RESET_HANDLER. Records sticky cause bits, the first cause and
//  a saturating violation count for post-reset software readout.
// PARAMETERS
//  RESET_HANDLER  16'h0000  PC the core must fetch after reset release
//  HOLD_CYCLES    8         cycles cpu_reset stays asserted (>=1)
//  PC_TIMEOUT     16        cycles allowed after release for pc==RESET_HANDLER (>=1)
//  CNT_W          8         width of violation counter
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high block reset (power-on/PUC)
//  viol         in   6      violation pulses: [0]X_stack [1]AC [2]atomicity [3]dma_AC [4]dma_detect [5]dma_X_stack
//  pc           in   16     current core PC
//  cause_clr    in   1      software clear of cause/first_cause/timeout_flag (honoured in IDLE only)
//  cpu_reset    out  1      reset to core, registered
//  cause        out  6      sticky OR of all viol bits since last clear
//  first_cause  out  3      1..6 = index+1 of first violation since clear, 0 = none
//  viol_cnt     out  CNT_W  saturating count of violation events (entries into HOLD)
//  timeout_flag out  1      sticky: core missed RESET_HANDLER within PC_TIMEOUT
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately.
//  - States: IDLE, HOLD, WAIT_PC.
//  - IDLE: cpu_reset=0. |viol -> HOLD next edge; cpu_reset=1 at that edge (latency 1 cycle).
//  - HOLD: cpu_reset=1; hold_cnt counts 0..HOLD_CYCLES-1. Any viol in HOLD reloads hold_cnt=0.
//    Exit to WAIT_PC when hold_cnt==HOLD_CYCLES-1 and viol==0; cpu_reset drops on the transition edge.
//    Net: isolated pulse -> cpu_reset high exactly HOLD_CYCLES cycles.
//  - WAIT_PC: cpu_reset=0; to_cnt counts cycles. pc==RESET_HANDLER -> IDLE.
//    viol during WAIT_PC -> HOLD (new event). to_cnt==PC_TIMEOUT-1 without match -> HOLD,
//    set timeout_flag, counts as event. Simultaneous pc match and viol: viol wins (-> HOLD).
//  - cause |= viol every cycle, any state. first_cause loads the lowest set viol index+1 only when
//    first_cause==0; simultaneous bits: lowest index wins.
//  - viol_cnt increments by 1 per entry into HOLD from IDLE or WAIT_PC (not on re-trigger inside HOLD).
//    Saturates at 2^CNT_W-1. Cleared only by reset.
//  - cause_clr in IDLE clears cause, first_cause, timeout_flag. If viol is also set that cycle, the
//    new bits win (clear, then OR). cause_clr outside IDLE is ignored.
//  - All outputs registered; no combinational path viol->cpu_reset.
// STRUCTURE
//  - Shared package/defines: state encodings (IDLE=2'd0, HOLD=2'd1, WAIT_PC=2'd2), viol bit indices,
//    NUM_MON=6.
//  - One sub-module: viol_prio_enc (6-bit -> 3-bit lowest-index encoder, 0=none). Remainder is flat FSM.
// TESTING
//  1. Reset, viol=6'b000010 one cycle -> cpu_reset=1 next cycle for 8 cycles; cause=6'h02,
//     first_cause=2, viol_cnt=1, busy until pc==16'h0000.
//  2. viol=6'b100001 simultaneously -> first_cause=1, cause=6'h21; then viol=6'h04 -> first_cause
//     stays 1, cause=6'h25.
//  3. Re-trigger: viol at HOLD cycle 5 -> cpu_reset held 5+8=13 cycles total; viol_cnt +1 only.
//  4. After release, pc held at 16'h1234 for 16 cycles -> timeout_flag=1, cpu_reset re-asserts,
//     viol_cnt +1; then pc=16'h0000 -> IDLE.
//  5. Saturation: 300 isolated events with CNT_W=8 -> viol_cnt=255; cause_clr in HOLD ignored,
//     in IDLE clears cause/first_cause/timeout_flag, viol_cnt stays 255.
//  6. reset asserted in HOLD cycle 3 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/violation_reset_ctrl_pkg.sv
// Shared definitions for the violation reset controller: FSM encoding and monitor bit map.
`default_nettype none

package violation_reset_ctrl_pkg;

  localparam int NUM_MON = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_PC = 2'd2
  } state_t;

  localparam int VB_X_STACK     = 0;
  localparam int VB_AC          = 1;
  localparam int VB_ATOMICITY   = 2;
  localparam int VB_DMA_AC      = 3;
  localparam int VB_DMA_DETECT  = 4;
  localparam int VB_DMA_X_STACK = 5;

endpackage

`default_nettype wire

// File: rtl/violation_reset_ctrl_prio_enc.sv
// Lowest-index priority encoder: returns index+1 of the lowest set violation bit, 0 when none.
`default_nettype none

module viol_prio_enc
  import violation_reset_ctrl_pkg::*;
(
  input  logic [NUM_MON-1:0] viol,
  output logic [2:0]         idx
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = 3'd0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (viol[i]) idx = 3'(i + 1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/violation_reset_ctrl.sv
// Stretches monitor violation pulses into a fixed-length CPU reset, checks the restart PC,
// and keeps sticky cause / first-cause / event-count status for software.
`default_nettype none

module violation_reset_ctrl
  import violation_reset_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          HOLD_CYCLES   = 8,
  parameter int          PC_TIMEOUT    = 16,
  parameter int          CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_MON-1:0] viol,
  input  logic [15:0]        pc,
  input  logic               cause_clr,
  output logic               cpu_reset,
  output logic [NUM_MON-1:0] cause,
  output logic [2:0]         first_cause,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic               timeout_flag,
  output logic               busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (PC_TIMEOUT  > 1) ? $clog2(PC_TIMEOUT)  : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(PC_TIMEOUT - 1);

  state_t               state, state_nx;
  logic [HW-1:0]        hold_cnt, hold_nx;
  logic [TW-1:0]        to_cnt, to_nx;
  logic                 enter_hold;
  logic                 timeout_evt;
  logic                 any_viol;
  logic                 clr_now;
  logic [2:0]           enc_idx;
  logic [NUM_MON-1:0]   cause_nx;
  logic [2:0]           first_nx;
  logic [2:0]           first_base;
  logic [CNT_W-1:0]     viol_cnt_nx;
  logic                 timeout_nx;

  viol_prio_enc u_prio_enc (
    .viol (viol),
    .idx  (enc_idx)
  );

  assign any_viol = |viol;
  assign clr_now  = cause_clr && (state == IDLE);

  always_comb begin
    state_nx    = state;
    hold_nx     = hold_cnt;
    to_nx       = to_cnt;
    enter_hold  = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE: begin
        if (any_viol) begin
          state_nx   = HOLD;
          hold_nx    = '0;
          enter_hold = 1'b1;
        end
      end
      HOLD: begin
        if (any_viol) begin
          hold_nx = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = WAIT_PC;
          to_nx    = '0;
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      WAIT_PC: begin
        // A fresh violation outranks a matching PC on the same cycle.
        if (any_viol) begin
          state_nx   = HOLD;
          hold_nx    = '0;
          enter_hold = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          state_nx = IDLE;
        end else if (to_cnt == TO_LAST) begin
          state_nx    = HOLD;
          hold_nx     = '0;
          enter_hold  = 1'b1;
          timeout_evt = 1'b1;
        end else begin
          to_nx = to_cnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status: a software clear is applied first so same-cycle violations survive it.
  always_comb begin
    cause_nx    = (clr_now ? '0 : cause) | viol;
    first_base  = clr_now ? 3'd0 : first_cause;
    first_nx    = (first_base == 3'd0) ? enc_idx : first_base;
    timeout_nx  = (clr_now ? 1'b0 : timeout_flag) | timeout_evt;
    viol_cnt_nx = viol_cnt;
    if (enter_hold && (viol_cnt != {CNT_W{1'b1}})) viol_cnt_nx = viol_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      to_cnt       <= '0;
      cpu_reset    <= 1'b0;
      busy         <= 1'b0;
      cause        <= '0;
      first_cause  <= 3'd0;
      viol_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nx;
      hold_cnt     <= hold_nx;
      to_cnt       <= to_nx;
      cpu_reset    <= (state_nx == HOLD);
      busy         <= (state_nx != IDLE);
      cause        <= cause_nx;
      first_cause  <= first_nx;
      viol_cnt     <= viol_cnt_nx;
      timeout_flag <= timeout_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_violation_reset_ctrl.sv
// Directed self-checking bench for violation_reset_ctrl with hand-computed expectations.
`default_nettype none

module tb_violation_reset_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;
  logic        cpu_reset;
  logic [5:0]  cause;
  logic [2:0]  first_cause;
  logic [7:0]  viol_cnt;
  logic        timeout_flag;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  violation_reset_ctrl #(
    .RESET_HANDLER (16'h0000),
    .HOLD_CYCLES   (8),
    .PC_TIMEOUT    (16),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .viol         (viol),
    .pc           (pc),
    .cause_clr    (cause_clr),
    .cpu_reset    (cpu_reset),
    .cause        (cause),
    .first_cause  (first_cause),
    .viol_cnt     (viol_cnt),
    .timeout_flag (timeout_flag),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      step();
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // Caller has just observed cpu_reset high with n already counting that cycle.
  task automatic count_high();
    while (n < 100) begin
      step();
      if (!cpu_reset) break;
      n++;
    end
  endtask

  task automatic one_event(input logic [5:0] v);
    viol = v;
    step();
    viol = 6'h00;
    wait_idle(40);
  endtask

  initial begin
    reset = 1'b1; viol = 6'h00; pc = 16'h1234; cause_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_cause", cause, 0);
    chk("rst_first", first_cause, 0);
    chk("rst_cnt", viol_cnt, 0);
    chk("rst_tflag", timeout_flag, 0);
    chk("rst_busy", busy, 0);

    // 1: isolated AC pulse
    viol = 6'b000010;
    step();
    viol = 6'h00;
    chk("t1_cpu_reset", cpu_reset, 1);
    chk("t1_cause", cause, 6'h02);
    chk("t1_first", first_cause, 2);
    chk("t1_cnt", viol_cnt, 1);
    n = 1;
    count_high();
    chk("t1_hold_len", n, 8);
    chk("t1_busy_wait", busy, 1);
    pc = 16'h0000;
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_tflag", timeout_flag, 0);

    // 2: clear + simultaneous bits, lowest index wins; later bit only ORs
    cause_clr = 1'b1; viol = 6'b100001; pc = 16'h1234;
    step();
    cause_clr = 1'b0; viol = 6'h00;
    chk("t2_cause", cause, 6'h21);
    chk("t2_first", first_cause, 1);
    viol = 6'h04;
    step();
    viol = 6'h00;
    chk("t2_cause2", cause, 6'h25);
    chk("t2_first2", first_cause, 1);
    chk("t2_cnt", viol_cnt, 2);
    pc = 16'h0000;
    wait_idle(40);

    // 3: re-trigger during the fifth HOLD cycle
    pc = 16'h1234;
    viol = 6'h01;
    step();
    viol = 6'h00;
    n = 1;
    repeat (4) begin step(); n++; end
    viol = 6'h01;
    step();
    viol = 6'h00;
    n++;
    count_high();
    chk("t3_hold_len", n, 13);
    chk("t3_cnt", viol_cnt, 3);

    // 4: core never reaches the handler -> timeout re-asserts reset
    repeat (15) step();
    chk("t4_pre_cpu_reset", cpu_reset, 0);
    chk("t4_pre_tflag", timeout_flag, 0);
    step();
    chk("t4_cpu_reset", cpu_reset, 1);
    chk("t4_tflag", timeout_flag, 1);
    chk("t4_cnt", viol_cnt, 4);
    pc = 16'h0000;
    wait_idle(40);
    chk("t4_tflag_sticky", timeout_flag, 1);

    // 5: counter saturation and clear gating
    for (int e = 0; e < 300; e++) one_event(6'h10);
    chk("t5_cnt_sat", viol_cnt, 255);
    viol = 6'h08;
    step();
    viol = 6'h00; cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    chk("t5_hold_clr_cause", cause, 6'h3D);
    chk("t5_hold_clr_first", first_cause, 1);
    chk("t5_hold_clr_tflag", timeout_flag, 1);
    wait_idle(40);
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    chk("t5_clr_cause", cause, 0);
    chk("t5_clr_first", first_cause, 0);
    chk("t5_clr_tflag", timeout_flag, 0);
    chk("t5_cnt_kept", viol_cnt, 255);

    // Viol beats a matching PC in WAIT_PC
    pc = 16'h1234;
    viol = 6'h20;
    step();
    viol = 6'h00;
    n = 1;
    count_high();
    chk("wp_busy", busy, 1);
    pc = 16'h0000; viol = 6'h02;
    step();
    viol = 6'h00;
    chk("wp_viol_wins", cpu_reset, 1);
    chk("wp_first", first_cause, 6);

    // 6: reset in the third HOLD cycle aborts everything
    step(); step();
    chk("t6_pre_cpu_reset", cpu_reset, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_cpu_reset", cpu_reset, 0);
    chk("t6_cause", cause, 0);
    chk("t6_first", first_cause, 0);
    chk("t6_cnt", viol_cnt, 0);
    chk("t6_tflag", timeout_flag, 0);
    chk("t6_busy", busy, 0);
    step();
    chk("t6_stays_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
